aurora_tx_frame_arbiter: RTL

//  Frame-level round-robin arbiter sharing one Aurora TX FIFO among SRC_CNT AXI-S sources.
//  - Locks onto one source for a whole frame (up to and including tlast), so frames never interleave.
//  - Forwards the frame through a registered skid stage into the FIFO input.
//  - Grants a new frame only while the FIFO reports fifo_ready.

---
 rtl/aurora_tx_frame_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/aurora_tx_frame_arbiter.sv
// Frame-locked round-robin arbiter that shares one Aurora TX FIFO among SRC_CNT AXI-S
// sources, forwarding the granted frame through a 2-entry registered skid stage.
module aurora_tx_frame_arbiter #(
    parameter int  DATA_W  = 8,
    parameter int  KEEP_W  = DATA_W / 8,
    parameter int  SRC_CNT = 4,
    localparam int SEL_W   = $clog2(SRC_CNT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_ready,
    input  logic [SRC_CNT*DATA_W-1:0] i_tdata,
    input  logic [SRC_CNT*KEEP_W-1:0] i_tkeep,
    input  logic [SRC_CNT-1:0]        i_tvalid,
    input  logic [SRC_CNT-1:0]        i_tlast,
    output logic [SRC_CNT-1:0]        i_tready,
    output logic [DATA_W-1:0]         o_tdata,
    output logic [KEEP_W-1:0]         o_tkeep,
    output logic                      o_tvalid,
    output logic                      o_tlast,
    input  logic                      o_tready,
    output logic [SEL_W-1:0]          grant_id,
    output logic                      busy
);
    typedef enum logic {IDLE, XFER} state_t;

    localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(SRC_CNT - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  winner, idx;
    logic              found;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [KEEP_W-1:0] keep0_q, keep0_d, keep1_q, keep1_d;
    logic              last0_q, last0_d, last1_q, last1_d;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              sel_valid, sel_last;
    logic              in_ready, push, pop;

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int k = 0; k < SRC_CNT; k++) begin
            if (grant_q == SEL_W'(k)) begin
                sel_data  = i_tdata[k*DATA_W +: DATA_W];
                sel_keep  = i_tkeep[k*KEEP_W +: KEEP_W];
                sel_valid = i_tvalid[k];
                sel_last  = i_tlast[k];
            end
        end
    end

    // Search ascends from the source after the last grant; idle sources keep their place.
    always_comb begin
        winner = grant_q;
        idx    = grant_q;
        found  = 1'b0;
        for (int i = 1; i <= SRC_CNT; i++) begin
            idx = SEL_W'((int'(grant_q) + i) % SRC_CNT);
            if (!found && i_tvalid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = (state_q == XFER) && (cnt_q != 2'd2);
        push     = in_ready && sel_valid;
        pop      = (cnt_q != 2'd0) && o_tready;

        i_tready = '0;
        for (int k = 0; k < SRC_CNT; k++) begin
            if (in_ready && (grant_q == SEL_W'(k))) begin
                i_tready[k] = 1'b1;
            end
        end

        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (fifo_ready && found) begin
                    state_d = XFER;
                    grant_d = winner;
                end
            end
            XFER: begin
                if (push && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entry 0 always holds the word on o_*, so a stalled output never changes.
        cnt_d   = cnt_q;
        data0_d = data0_q;
        keep0_d = keep0_q;
        last0_d = last0_q;
        data1_d = data1_q;
        keep1_d = keep1_q;
        last1_d = last1_q;
        case ({push, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    data0_d = sel_data;
                    keep0_d = sel_keep;
                    last0_d = sel_last;
                end else begin
                    data1_d = sel_data;
                    keep1_d = sel_keep;
                    last1_d = sel_last;
                end
            end
            2'b01: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd2) begin
                    data0_d = data1_q;
                    keep0_d = keep1_q;
                    last0_d = last1_q;
                end
            end
            2'b11: begin
                data0_d = sel_data;
                keep0_d = sel_keep;
                last0_d = sel_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= LAST_SRC;
            cnt_q   <= 2'd0;
            data0_q <= '0;
            keep0_q <= '0;
            last0_q <= 1'b0;
            data1_q <= '0;
            keep1_q <= '0;
            last1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            data0_q <= data0_d;
            keep0_q <= keep0_d;
            last0_q <= last0_d;
            data1_q <= data1_d;
            keep1_q <= keep1_d;
            last1_q <= last1_d;
        end
    end

    assign o_tvalid = (cnt_q != 2'd0);
    assign o_tdata  = data0_q;
    assign o_tkeep  = keep0_q;
    assign o_tlast  = last0_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == XFER);

endmodule
